// File: rtl/mips_io_pkg.sv
// Shared constants for the MIPS board IO path: debounce FSM encoding, counter sizing and
// the memory-mapped IO port addresses.
package mips_io_pkg;

   typedef enum logic {
      DEB_STABLE   = 1'b0,
      DEB_CHANGING = 1'b1
   } deb_state_e;

   localparam int unsigned DEB_STABLE_CYCLES = 50000;
   localparam int unsigned DEB_CNT_W         = 16;

   localparam logic [15:0] IO_SWITCH_ADDR  = 16'hfff0;
   localparam logic [15:0] IO_DISPLAY_ADDR = 16'hfffa;

endpackage

// File: rtl/io_debounce_bit.sv
// Single-bit conditioner: two-flop synchroniser, bounce filter FSM and rising-edge pulse.
// The pulse flop exists only when MIPS_IO_DEBOUNCE_PULSE_EN is defined.
module io_debounce_bit
   import mips_io_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEB_CNT_W
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic deb_out,
   output logic rise_pulse
);

   // The edge that enters CHANGING counts as the first differing cycle.
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   deb_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             deb_q;
`ifdef MIPS_IO_DEBOUNCE_PULSE_EN
   logic             pulse_q;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= DEB_STABLE;
         cnt_q   <= '0;
         deb_q   <= 1'b0;
`ifdef MIPS_IO_DEBOUNCE_PULSE_EN
         pulse_q <= 1'b0;
`endif
      end else begin
         s1_q <= raw_in;
         s2_q <= s1_q;
`ifdef MIPS_IO_DEBOUNCE_PULSE_EN
         pulse_q <= 1'b0;
`endif
         unique case (state_q)
            DEB_STABLE: begin
               if (s2_q != deb_q) begin
                  if (STABLE_CYCLES == 1) begin
                     deb_q <= s2_q;
`ifdef MIPS_IO_DEBOUNCE_PULSE_EN
                     pulse_q <= s2_q;
`endif
                  end else begin
                     state_q <= DEB_CHANGING;
                     cnt_q   <= CNT_W'(1);
                  end
               end
            end
            DEB_CHANGING: begin
               if (s2_q == deb_q) begin
                  state_q <= DEB_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == LastCnt) begin
                  deb_q   <= s2_q;
                  state_q <= DEB_STABLE;
                  cnt_q   <= '0;
`ifdef MIPS_IO_DEBOUNCE_PULSE_EN
                  pulse_q <= s2_q;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= DEB_STABLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign deb_out = deb_q;
`ifdef MIPS_IO_DEBOUNCE_PULSE_EN
   assign rise_pulse = pulse_q;
`else
   assign rise_pulse = 1'b0;
`endif

endmodule

// File: rtl/io_debounce.sv
// Board-input conditioner: N_IN independent debounced bits (SW1, SW0, PB0) feeding the switch
// port. Rising-edge pulses are built only with MIPS_IO_DEBOUNCE_PULSE_EN; otherwise zero.
module io_debounce
   import mips_io_pkg::*;
#(
   parameter int unsigned N_IN          = 3,
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int unsigned CNT_W         = DEB_CNT_W
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_IN-1:0] raw_in,
   output logic [N_IN-1:0] deb_out,
   output logic [N_IN-1:0] rise_pulse
);

   for (genvar i = 0; i < N_IN; i++) begin : g_bit
      io_debounce_bit #(
         .STABLE_CYCLES(STABLE_CYCLES),
         .CNT_W        (CNT_W)
      ) u_bit (
         .clock     (clock),
         .reset     (reset),
         .raw_in    (raw_in[i]),
         .deb_out   (deb_out[i]),
         .rise_pulse(rise_pulse[i])
      );
   end

endmodule

// File: tb/tb_io_debounce.sv
// Directed bench for io_debounce: per-cycle vector table plus hand sequences for async reset
// mid-count and the STABLE_CYCLES=1 pass-through instance.
module tb_io_debounce;

   logic       clock;
   logic       reset;
   logic [2:0] raw4;
   logic [2:0] deb4;
   logic [2:0] pls4;
   logic [2:0] raw1;
   logic [2:0] deb1;
   logic [2:0] pls1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [2:0] raw;
      logic [2:0] deb;
      logic [2:0] pls;
   } vec_t;

   vec_t tbl[$];

   io_debounce #(.N_IN(3), .STABLE_CYCLES(4), .CNT_W(16)) dut4 (
      .clock     (clock),
      .reset     (reset),
      .raw_in    (raw4),
      .deb_out   (deb4),
      .rise_pulse(pls4)
   );

   io_debounce #(.N_IN(3), .STABLE_CYCLES(1), .CNT_W(16)) dut1 (
      .clock     (clock),
      .reset     (reset),
      .raw_in    (raw1),
      .deb_out   (deb1),
      .rise_pulse(pls1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [2:0] pexp(input logic [2:0] p);
`ifdef MIPS_IO_DEBOUNCE_PULSE_EN
      return p;
`else
      return 3'b000;
`endif
   endfunction

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic addv(input logic [2:0] r, input logic [2:0] d, input logic [2:0] p);
      vec_t v;
      v.raw = r;
      v.deb = d;
      v.pls = p;
      tbl.push_back(v);
   endtask

   initial begin
      // Release from reset with all pins high: all bits rise together on edge 6.
      for (int i = 0; i < 8; i++)
         addv(3'b111, (i >= 5) ? 3'b111 : 3'b000, (i == 5) ? 3'b111 : 3'b000);
      // SW1 released: falls on edge 6, no pulse.
      for (int i = 0; i < 8; i++)
         addv(3'b011, (i >= 5) ? 3'b011 : 3'b111, 3'b000);
      for (int i = 0; i < 8; i++)
         addv(3'b000, (i >= 5) ? 3'b000 : 3'b011, 3'b000);
      // Clean PB0 press.
      for (int i = 0; i < 8; i++)
         addv(3'b001, (i >= 5) ? 3'b001 : 3'b000, (i == 5) ? 3'b001 : 3'b000);
      // SW0 bounces 1,0,1,0 then holds; last 0->1 capture is row 4, so rise on row 9.
      addv(3'b011, 3'b001, 3'b000);
      addv(3'b001, 3'b001, 3'b000);
      addv(3'b011, 3'b001, 3'b000);
      addv(3'b001, 3'b001, 3'b000);
      for (int i = 4; i < 12; i++)
         addv(3'b011, (i >= 9) ? 3'b011 : 3'b001, (i == 9) ? 3'b010 : 3'b000);

      reset = 1'b1;
      raw4  = 3'b111;
      raw1  = 3'b000;
      #2;
      chk("reset_async_deb", deb4, 3'b000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         chk("in_reset_deb", deb4, 3'b000);
         chk("in_reset_pulse", pls4, 3'b000);
      end

      @(negedge clock);
      reset = 1'b0;
      foreach (tbl[i]) begin
         raw4 = tbl[i].raw;
         @(posedge clock);
         #1;
         chk($sformatf("vec%0d_deb", i), deb4, tbl[i].deb);
         chk($sformatf("vec%0d_pulse", i), pls4, pexp(tbl[i].pls));
         @(negedge clock);
      end

      // Reset in the middle of SW1's count; the count must restart from scratch.
      raw4 = 3'b111;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock);
         #1;
         chk("precount_deb", deb4, 3'b011);
      end
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("midreset_deb", deb4, 3'b000);
      chk("midreset_pulse", pls4, 3'b000);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("postreset%0d_deb", k), deb4, (k >= 5) ? 3'b111 : 3'b000);
         chk($sformatf("postreset%0d_pulse", k), pls4, pexp((k == 5) ? 3'b111 : 3'b000));
      end

      // STABLE_CYCLES=1: no filtering, output follows s2 on edge 3.
      @(negedge clock);
      raw1 = 3'b001;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock);
         #1;
         chk($sformatf("sc1_%0d_deb", k), deb1, (k >= 2) ? 3'b001 : 3'b000);
         chk($sformatf("sc1_%0d_pulse", k), pls1, pexp((k == 2) ? 3'b001 : 3'b000));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
